// File: rtl/fir_pkg.sv
// Shared types and helpers for the time-multiplexed FIR sequencer.
// FSM state enum, accumulator sizing and output clamp/wrap helper.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  // Widest value the output reducer works on; must cover the accumulator.
  localparam int MAXW = 128;

  function automatic int acc_width(input int width, input int taps);
    return 2 * width + $clog2(taps) + 1;
  endfunction

  // Clamp v to the signed range of 'width' bits when sat is set;
  // otherwise pass it through so the caller keeps the low bits.
  function automatic logic signed [MAXW-1:0] fir_reduce(
    input logic signed [MAXW-1:0] v,
    input int                     width,
    input bit                     sat
  );
    logic signed [MAXW-1:0] one;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    one = 1;
    hi  = (one <<< (width - 1)) - one;
    lo  = -hi - one;
    if (sat && v > hi) return hi;
    if (sat && v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate shared by all taps.
// Ports: clk, rst_n, clear, en, a, b -> sum (acc + a*b, combinational).
module fir_mac_unit
  import fir_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ACCW  = 36
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [ACCW-1:0]  sum
);

  logic signed [ACCW-1:0]    acc;
  logic signed [2*WIDTH-1:0] prod;

  assign prod = a * b;
  // Exposed so the sequencer can register the final sum on the last tap.
  assign sum  = acc + ACCW'(prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR controller: delay line, coefficient bank, one tap per cycle.
// Ports: in valid/ready/data, coeff write port, out valid/ready/data, busy.
// Macro FIR_SAT_EN: clamp output after the shift instead of wrapping.
module fir_mac_sequencer
  import fir_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int TAPS  = 8,
  parameter  int SHIFT = 15,
  localparam int AW    = $clog2(TAPS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    coeff_we,
  input  logic [AW-1:0]           coeff_addr,
  input  logic signed [WIDTH-1:0] coeff_wdata,
  output logic                    coeff_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    busy
);

  localparam int ACCW = acc_width(WIDTH, TAPS);

`ifdef FIR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  state_t                 state;
  logic [AW-1:0]          idx;
  logic signed [WIDTH-1:0] x [TAPS];
  logic signed [WIDTH-1:0] c [TAPS];
  logic signed [ACCW-1:0] sum;
  logic                   take;

  assign in_ready    = (state == IDLE);
  assign coeff_ready = (state == IDLE);
  assign busy        = (state == MAC) || (state == OUT);
  assign take        = in_valid && (state == IDLE);

  fir_mac_unit #(
    .WIDTH (WIDTH),
    .ACCW  (ACCW)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (take),
    .en    (state == MAC),
    .a     (x[idx]),
    .b     (c[idx]),
    .sum   (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          // Write lands before the MAC pass reads the bank.
          if (coeff_we) c[coeff_addr] <= coeff_wdata;
          if (in_valid) begin
            for (int k = TAPS - 1; k > 0; k--) x[k] <= x[k-1];
            x[0]  <= in_data;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          idx <= idx + 1'b1;
          if (idx == AW'(TAPS - 1)) begin
            out_data  <= WIDTH'(fir_reduce(
                           MAXW'(sum) >>> SHIFT, WIDTH, SAT));
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scoreboard bench for fir_mac_sequencer (SHIFT=0 and SHIFT=15 copies).
// Expected sums queued on input handshake, compared on output transfer.
module tb_fir_mac_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        coeff_we = 1'b0;
  logic [2:0]  coeff_addr = '0;
  logic [15:0] coeff_wdata = '0;
  logic        out_ready = 1'b1;
  logic        in_ready, coeff_ready, out_valid, busy;
  logic [15:0] out_data;
  logic        in_ready_s, coeff_ready_s, out_valid_s, busy_s;
  logic [15:0] out_data_s;

  int checks = 0;
  int errors = 0;
  int nout = 0;
  longint q[$];
  logic [15:0] got[$];
  logic [15:0] last_s;
  logic signed [15:0] mx [8];
  logic signed [15:0] mc [8];

  always #5 clk = ~clk;

  fir_mac_sequencer #(.WIDTH(16), .TAPS(8), .SHIFT(0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_wdata(coeff_wdata), .coeff_ready(coeff_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  fir_mac_sequencer #(.WIDTH(16), .TAPS(8), .SHIFT(15)) u_dut_s (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_wdata(coeff_wdata), .coeff_ready(coeff_ready_s),
    .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .busy(busy_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_out(input longint acc,
                                          input int sh);
    longint v;
    v = acc >>> sh;
`ifdef FIR_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  // Reference model and scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    longint s;
    longint e;
    if (!rst_n) begin
      for (int k = 0; k < 8; k++) begin
        mx[k] = '0;
        mc[k] = '0;
      end
      q.delete();
    end else begin
      if (coeff_we && coeff_ready) mc[coeff_addr] = coeff_wdata;
      if (in_valid && in_ready) begin
        for (int k = 7; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = in_data;
        s = 0;
        for (int k = 0; k < 8; k++)
          s += longint'(mx[k]) * longint'(mc[k]);
        q.push_back(s);
      end
      if (out_valid && out_ready) begin
        chk("out_valid_s", {63'd0, out_valid_s}, 64'd1);
        if (q.size() == 0) begin
          chk("unexpected_out", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("out", {48'd0, out_data}, {48'd0, ref_out(e, 0)});
          chk("out_s", {48'd0, out_data_s}, {48'd0, ref_out(e, 15)});
          last_s = out_data_s;
          got.push_back(out_data);
          nout++;
        end
      end
    end
  end

  task automatic send(input logic [15:0] d, input logic we = 1'b0,
                      input logic [2:0] wa = '0,
                      input logic [15:0] wd = '0);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_data = d;
    coeff_we = we;
    coeff_addr = wa;
    coeff_wdata = wd;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    coeff_we = 1'b0;
  endtask

  task automatic wcoef(input logic [2:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    coeff_we = 1'b1;
    coeff_addr = a;
    coeff_wdata = d;
    @(posedge clk); #1;
    coeff_we = 1'b0;
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic impulse();
    send(16'd1);
    for (int i = 0; i < 7; i++) send(16'd0);
    drain();
  endtask

  initial begin
    int lat;
    int bad;
    int n0;
    logic [15:0] d0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_coeff_ready", {63'd0, coeff_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {48'd0, out_data}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst_n = 1'b1;

    // Impulse response walks the coefficient bank.
    for (int k = 0; k < 8; k++) wcoef(3'(k), 16'(k + 1));
    got.delete();
    impulse();
    chk("imp_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("imp_%0d", i), {48'd0, got[i]}, 64'(i + 1));

    // Latency and in_ready low while busy.
    send(16'd5);
    lat = -1;
    bad = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      if (out_valid && lat < 0) lat = cyc;
      if (cyc <= 9 && in_ready) bad++;
      if (cyc == 10) chk("lat_idle", {63'd0, in_ready}, 64'd1);
    end
    chk("latency", 64'(lat), 64'd9);
    chk("lat_in_ready_low", 64'(bad), 64'd0);

    // Backpressure holds the result.
    out_ready = 1'b0;
    send(16'h1234);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    chk("bp_valid_seen", {63'd0, out_valid}, 64'd1);
    d0 = out_data;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || out_data != d0 || in_ready) bad++;
    end
    chk("bp_hold", 64'(bad), 64'd0);
    n0 = nout;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_one_xfer", 64'(nout - n0), 64'd1);
    chk("bp_out_valid", {63'd0, out_valid}, 64'd0);
    chk("bp_in_ready", {63'd0, in_ready}, 64'd1);

    // Overflow: clamp or wrap depending on build.
    for (int k = 0; k < 8; k++) wcoef(3'(k), 16'h7FFF);
    for (int i = 0; i < 8; i++) send(16'h7FFF);
    drain();
`ifdef FIR_SAT_EN
    chk("sat_s", {48'd0, last_s}, 64'h7FFF);
`else
    chk("sat_s", {48'd0, last_s}, 64'hFFF0);
`endif

    // Writes while busy are dropped.
    for (int k = 0; k < 8; k++) wcoef(3'(k), 16'(k + 1));
    for (int i = 0; i < 7; i++) send(16'd0);
    send(16'd0);
    coeff_we = 1'b1;
    coeff_addr = 3'd0;
    coeff_wdata = 16'd100;
    @(negedge clk);
    chk("busy_coeff_ready", {63'd0, coeff_ready}, 64'd0);
    @(posedge clk); #1;
    coeff_we = 1'b0;
    drain();
    got.delete();
    impulse();
    chk("gate_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("gate_%0d", i), {48'd0, got[i]}, 64'(i + 1));

    // Write and sample in the same IDLE cycle.
    got.delete();
    send(16'd3, 1'b1, 3'd0, 16'd5);
    drain();
    chk("same_cycle", {48'd0, (got.size() > 0) ? got[0] : 16'hDEAD},
        64'd15);

    // Reset mid-MAC.
    send(16'd2);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd1);
    got.delete();
    impulse();
    chk("mrst_count", 64'(got.size()), 64'd8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk($sformatf("mrst_%0d", i), {48'd0, got[i]}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
